clk_div_bank: RTL and testbench

//   Programmable clock-divider bank that replaces the single fixed/slow divider pair.
//   A shared prescaler divides clk into a base square wave, clk_base.
//   N_CH independent channels each generate clk_out[i] with period 2^k base periods,

---
 rtl/clk_div_bank.sv | 123 ++++++++++++
 tb/tb_clk_div_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Purpose: programmable clock-divider bank; a shared prescaler feeds N_CH channels of period 2^k base periods.
// Latency: update rise -> pending_o one clk later; new exponent takes effect at the channel's next clk_out rise.
// Backpressure: none; a capture while pending overwrites the held exponent (last value wins).
//
// Ports:
//   clk, rst     reference clock, asynchronous active-high reset
//   update_i     per-channel update request (level; the rising edge captures)
//   prog_in_i    requested exponent, channel i at [i*PROG_W +: PROG_W]
//   clk_base_o   prescaled base clock, 50% duty, period 2*BASE_HALF_COUNT clk
//   clk_out_o    channel clocks, 50% duty, period 2^k base periods
//   prog_out_o   exponent currently in effect per channel
//   pending_o    captured exponent waiting for the channel's next rising edge
module clk_div_bank #(
    parameter int BASE_HALF_COUNT = 5000000,
    parameter int N_CH            = 2,
    parameter int PROG_W          = 3,
    parameter int PROG_RST        = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        update_i,
    input  logic [N_CH*PROG_W-1:0] prog_in_i,
    output logic                   clk_base_o,
    output logic [N_CH-1:0]        clk_out_o,
    output logic [N_CH*PROG_W-1:0] prog_out_o,
    output logic [N_CH-1:0]        pending_o
);

    localparam int PCW = (BASE_HALF_COUNT > 1) ? $clog2(BASE_HALF_COUNT) : 1;
    // Half-period counter must reach 2^(2^PROG_W-1)-1 for the largest exponent.
    localparam int CW  = (1 << PROG_W) - 1;
    localparam logic [PCW-1:0]    PRE_TC  = PCW'(BASE_HALF_COUNT - 1);
    localparam logic [PROG_W-1:0] PROG_RV = PROG_W'(PROG_RST);

    logic [PCW-1:0]  pre_cnt_q, pre_cnt_d;
    logic            clk_base_q, clk_base_d;
    logic            half_tick;
    logic [N_CH-1:0] update_q;
    logic [N_CH-1:0] rise;

    always_comb begin
        half_tick  = (pre_cnt_q == PRE_TC);
        pre_cnt_d  = half_tick ? '0 : pre_cnt_q + PCW'(1);
        clk_base_d = clk_base_q ^ half_tick;
        rise       = update_i & ~update_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q  <= '0;
            clk_base_q <= 1'b0;
            update_q   <= '0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            clk_base_q <= clk_base_d;
            update_q   <= update_i;
        end
    end

    assign clk_base_o = clk_base_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0]     cnt_q, cnt_d;
        logic [CW-1:0]     term;
        logic              out_q, out_d;
        logic              pend_q, pend_d;
        logic [PROG_W-1:0] prog_q, prog_d;
        logic [PROG_W-1:0] pval_q, pval_d;

        always_comb begin
            cnt_d  = cnt_q;
            out_d  = out_q;
            pend_d = pend_q;
            prog_d = prog_q;
            pval_d = pval_q;
            // 2^k-1 built by shifting an all-ones mask, so no wider intermediate is needed.
            term   = {CW{1'b1}} >> (CW - int'(prog_q));

            if (half_tick) begin
                if (cnt_q == term) begin
                    cnt_d = '0;
                    out_d = ~out_q;
                    // Switching only on a 0->1 toggle keeps every phase at least
                    // min(old,new) half-periods long; the counter is already zero here.
                    if (!out_q && pend_q) begin
                        prog_d = pval_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Placed after the apply so a same-cycle capture re-arms pending
            // while the apply above still used the older held value.
            if (rise[i]) begin
                pval_d = prog_in_i[i*PROG_W +: PROG_W];
                pend_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                out_q  <= 1'b0;
                pend_q <= 1'b0;
                prog_q <= PROG_RV;
                pval_q <= PROG_RV;
            end else begin
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                pend_q <= pend_d;
                prog_q <= prog_d;
                pval_q <= pval_d;
            end
        end

        assign clk_out_o[i]                    = out_q;
        assign pending_o[i]                    = pend_q;
        assign prog_out_o[i*PROG_W +: PROG_W]  = prog_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Purpose: self-checking bench for clk_div_bank against a time-arithmetic reference model.
// Latency: outputs compared every cycle on the falling edge after the model steps on the rising edge.
// Backpressure: not applicable; stimulus is directed scenarios followed by random update traffic.
module tb_clk_div_bank;

    localparam int BHC = 4;
    localparam int NCH = 2;
    localparam int PW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    upd = '0;
    logic [5:0]    pin = '0;
    logic          clk_base;
    logic [1:0]    clk_out;
    logic [5:0]    prog_out;
    logic [1:0]    pending;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_bank #(
        .BASE_HALF_COUNT(BHC),
        .N_CH           (NCH),
        .PROG_W         (PW),
        .PROG_RST       (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .update_i   (upd),
        .prog_in_i  (pin),
        .clk_base_o (clk_base),
        .clk_out_o  (clk_out),
        .prog_out_o (prog_out),
        .pending_o  (pending)
    );

    always #5 clk = ~clk;

    // Reference model: each channel's level is derived from elapsed base
    // half-periods since its last phase start, using plain division.
    int   n_edges;
    int   m_start [2];
    int   m_k     [2];
    int   m_base  [2];
    int   m_lvl   [2];
    int   m_pend  [2];
    int   m_pk    [2];
    logic [1:0] m_upd_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_edges    = 0;
        m_upd_prev = '0;
        for (int c = 0; c < 2; c++) begin
            m_start[c] = 0; m_k[c] = 0; m_base[c] = 0;
            m_lvl[c]   = 0; m_pend[c] = 0; m_pk[c] = 0;
        end
    endtask

    task automatic model_step();
        int h, nl;
        n_edges++;
        if (n_edges % BHC == 0) begin
            h = n_edges / BHC;
            for (int c = 0; c < 2; c++) begin
                nl = m_base[c] ^ (((h - m_start[c]) >> m_k[c]) & 1);
                if (m_lvl[c] == 0 && nl == 1 && m_pend[c] == 1) begin
                    m_start[c] = h;
                    m_k[c]     = m_pk[c];
                    m_base[c]  = 1;
                    m_pend[c]  = 0;
                end
                m_lvl[c] = nl;
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (upd[c] && !m_upd_prev[c]) begin
                m_pk[c]   = int'(pin[c*3 +: 3]);
                m_pend[c] = 1;
            end
        end
        m_upd_prev = upd;
    endtask

    task automatic check_all();
        logic [1:0] e_out, e_pend;
        logic [5:0] e_prog;
        for (int c = 0; c < 2; c++) begin
            e_out[c]        = m_lvl[c][0];
            e_pend[c]       = m_pend[c][0];
            e_prog[c*3 +: 3] = m_k[c][2:0];
        end
        chk("clk_base", 32'(clk_base), 32'((n_edges / BHC) % 2));
        chk("clk_out",  32'(clk_out),  32'(e_out));
        chk("prog_out", 32'(prog_out), 32'(e_prog));
        chk("pending",  32'(pending),  32'(e_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [1:0] m, input logic [2:0] v0, input logic [2:0] v1);
        pin = {v1, v0};
        upd = m;
        tick();
        upd = '0;
        tick();
    endtask

    initial begin
        model_reset();
        run(3);
        // Reset state while held
        chk("rst_base", 32'(clk_base), 32'd0);
        chk("rst_out",  32'(clk_out),  32'd0);
        chk("rst_prog", 32'(prog_out), 32'd0);
        chk("rst_pend", 32'(pending),  32'd0);
        rst = 1'b0;

        // 1: free-running at k=0
        run(40);

        // 2: ch0 -> k=3
        pin = {3'd0, 3'd3};
        upd = 2'b01;
        tick();
        chk("t2_pend_lat", 32'(pending[0]), 32'd1);
        upd = '0;
        run(150);
        chk("t2_prog0", 32'(prog_out[2:0]), 32'd3);
        chk("t2_prog1", 32'(prog_out[5:3]), 32'd0);

        // 3: held update on ch1, value changes midway
        pin = {3'd2, 3'd0};
        upd = 2'b10;
        run(50);
        pin = {3'd5, 3'd0};
        run(50);
        upd = '0;
        run(100);
        chk("t3_prog1", 32'(prog_out[5:3]), 32'd2);
        chk("t3_pend1", 32'(pending[1]), 32'd0);

        // 4: ch0 to k=7, then two captures before the next rise
        pulse(2'b01, 3'd7, 3'd0);
        run(80);
        chk("t4_prog7", 32'(prog_out[2:0]), 32'd7);
        run(20);
        pulse(2'b01, 3'd1, 3'd0);
        run(30);
        pulse(2'b01, 3'd4, 3'd0);
        run(1100);
        chk("t4_prog4", 32'(prog_out[2:0]), 32'd4);

        // 5: both at k=5 with pending set, then async reset mid-cycle
        pulse(2'b11, 3'd5, 3'd5);
        run(300);
        pulse(2'b11, 3'd3, 3'd3);
        run(7);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_base", 32'(clk_base), 32'd0);
        chk("t5_async_out",  32'(clk_out),  32'd0);
        chk("t5_async_prog", 32'(prog_out), 32'd0);
        chk("t5_async_pend", 32'(pending),  32'd0);
        model_reset();
        run(3);
        rst = 1'b0;
        run(40);

        // 6: simultaneous update on both channels
        pulse(2'b11, 3'd1, 3'd6);
        run(1100);
        chk("t6_prog0", 32'(prog_out[2:0]), 32'd1);
        chk("t6_prog1", 32'(prog_out[5:3]), 32'd6);

        // Random update traffic
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 39) == 0) begin
                    upd[c] = ~upd[c];
                    pin[c*3 +: 3] = 3'($urandom_range(0, 5));
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
